// File: rtl/icache_refill_ctrl.sv
// Refill controller and tag/data store for a direct-mapped instruction cache.
// Hits answer one cycle after acceptance; misses go through a req/resp refill and are installed before replying.
module icache_refill_ctrl #(
    parameter int SETS   = 16,
    parameter int ADDR_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_pc,
    output logic              fetch_ready,
    output logic              fetch_valid,
    output logic [31:0]       fetch_instr,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    input  logic              mem_resp_valid,
    input  logic [31:0]       mem_resp_data,
    input  logic              inval,
    output logic [15:0]       miss_count
);
    localparam int SET_W = $clog2(SETS);
    localparam int BLK_W = ADDR_W - 3;
    localparam int TAG_W = BLK_W - SET_W;

    typedef enum logic [2:0] {IDLE, LOOKUP, REQ, WAIT, RESP} state_t;

    state_t           state;
    logic [SETS-1:0]  valid;
    logic [TAG_W-1:0] tag_mem  [SETS];
    logic [31:0]      data_mem [SETS];
    logic [BLK_W-1:0] blk_q;
    logic             lk_hit;
    logic             inval_pend;

    logic [BLK_W-1:0] req_blk;
    logic [SET_W-1:0] req_set;
    logic [TAG_W-1:0] req_tag;
    logic             req_hit;
    logic [SET_W-1:0] fill_set;
    logic [TAG_W-1:0] fill_tag;
    logic             unused_pc_bits;

    assign req_blk        = fetch_pc[ADDR_W-1:3];
    assign req_set        = req_blk[SET_W-1:0];
    assign req_tag        = req_blk[BLK_W-1:SET_W];
    assign req_hit        = valid[req_set] && (tag_mem[req_set] == req_tag);
    assign fill_set       = blk_q[SET_W-1:0];
    assign fill_tag       = blk_q[BLK_W-1:SET_W];
    assign unused_pc_bits = ^fetch_pc[2:0];

    assign fetch_ready = (state == IDLE) && !inval_pend;

    // Tag and data arrays carry no reset; only the valid bits qualify them.
    always_ff @(posedge clock) begin
        if (!reset && state == WAIT && mem_resp_valid) begin
            tag_mem[fill_set]  <= fill_tag;
            data_mem[fill_set] <= mem_resp_data;
        end
    end

    // The hit decision is taken at acceptance so fetch_valid can be a register
    // that is already high during LOOKUP. Arrays cannot change between the two.
    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            valid         <= '0;
            inval_pend    <= 1'b0;
            fetch_valid   <= 1'b0;
            fetch_instr   <= '0;
            mem_req_valid <= 1'b0;
            mem_req_addr  <= '0;
            miss_count    <= '0;
            blk_q         <= '0;
            lk_hit        <= 1'b0;
        end else begin
            if (inval) begin
                inval_pend <= 1'b1;
            end
            case (state)
                IDLE: begin
                    fetch_valid <= 1'b0;
                    if (inval_pend) begin
                        valid      <= '0;
                        inval_pend <= inval;
                    end else if (fetch_req) begin
                        blk_q       <= req_blk;
                        lk_hit      <= req_hit;
                        fetch_valid <= req_hit;
                        if (req_hit) begin
                            fetch_instr <= data_mem[req_set];
                        end
                        state <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    fetch_valid <= 1'b0;
                    if (lk_hit) begin
                        state <= IDLE;
                    end else begin
                        if (miss_count != '1) begin
                            miss_count <= miss_count + 1'b1;
                        end
                        mem_req_valid <= 1'b1;
                        mem_req_addr  <= {blk_q, 3'b000};
                        state         <= REQ;
                    end
                end
                REQ: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        state         <= WAIT;
                    end
                end
                WAIT: begin
                    if (mem_resp_valid) begin
                        valid[fill_set] <= 1'b1;
                        fetch_valid     <= 1'b1;
                        fetch_instr     <= mem_resp_data;
                        state           <= RESP;
                    end
                end
                RESP: begin
                    fetch_valid <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Directed bench for icache_refill_ctrl: expected words and request addresses
// are queued at issue time and popped by independent monitor/responder processes.
module tb_icache_refill_ctrl;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        fetch_req = 1'b0;
    logic [31:0] fetch_pc = '0;
    logic        fetch_ready;
    logic        fetch_valid;
    logic [31:0] fetch_instr;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;
    logic        inval;
    logic [15:0] miss_count;

    always #5 clock = ~clock;

    icache_refill_ctrl dut (
        .clock(clock), .reset(reset),
        .fetch_req(fetch_req), .fetch_pc(fetch_pc), .fetch_ready(fetch_ready),
        .fetch_valid(fetch_valid), .fetch_instr(fetch_instr),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
        .inval(inval), .miss_count(miss_count)
    );

    int          total = 0;
    int          bad = 0;
    logic [31:0] exp_q[$];
    logic [31:0] addr_q[$];
    logic [15:0] exp_miss = '0;
    int          stall = 0;
    bit          stray = 1'b0;
    bit          inval_on_resp = 1'b0;
    bit          drop_resp = 1'b0;
    bit          parked = 1'b0;
    bit          release_resp = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    function automatic logic [31:0] memval(input logic [31:0] addr);
        if (addr == 32'h100) return 32'h91000AD6;
        return {addr[15:0], ~addr[15:0]};
    endfunction

    // Scoreboard monitor for returned instructions.
    initial begin
        forever begin
            @(negedge clock);
            if (fetch_valid) begin
                if (exp_q.size() == 0) check("spurious fetch_valid", {31'b0, fetch_valid}, 32'h0);
                else check("fetch_instr", fetch_instr, exp_q.pop_front());
            end
        end
    end

    // Backing-memory responder; checks request address and stability while stalled.
    initial begin
        logic [31:0] a;
        int          t;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
        inval          = 1'b0;
        forever begin
            @(negedge clock);
            mem_resp_valid = 1'b0;
            inval          = 1'b0;
            if (mem_req_valid && !reset) begin
                a = mem_req_addr;
                if (addr_q.size() == 0) check("spurious mem_req_valid", {31'b0, mem_req_valid}, 32'h0);
                else check("mem_req_addr", a, addr_q.pop_front());
                for (int i = 0; i < stall; i++) begin
                    if (stray && i == 1) begin
                        mem_resp_valid = 1'b1;
                        mem_resp_data  = 32'hDEADBEEF;
                    end
                    @(negedge clock);
                    mem_resp_valid = 1'b0;
                    check("req_valid_hold", {31'b0, mem_req_valid}, 32'h1);
                    check("req_addr_hold", mem_req_addr, a);
                end
                mem_req_ready = 1'b1;
                @(negedge clock);
                mem_req_ready = 1'b0;
                if (drop_resp) begin
                    parked = 1'b1;
                    t = 0;
                    while (!release_resp && t < 100) begin
                        @(negedge clock);
                        t++;
                    end
                    parked         = 1'b0;
                    mem_resp_valid = 1'b1;
                    mem_resp_data  = memval(a);
                end else begin
                    mem_resp_valid = 1'b1;
                    mem_resp_data  = memval(a);
                    inval          = inval_on_resp;
                end
            end
        end
    end

    task automatic fetch(input logic [31:0] pc, input bit miss, input int lat, input bit expect_resp);
        int          t;
        logic [31:0] line;
        line = {pc[31:3], 3'b000};
        t = 0;
        while (!fetch_ready && t < 50) begin
            @(negedge clock);
            t++;
        end
        check("fetch_ready wait", {31'b0, fetch_ready}, 32'h1);
        if (expect_resp) exp_q.push_back(memval(line));
        if (miss) begin
            addr_q.push_back(line);
            if (expect_resp && exp_miss != 16'hFFFF) exp_miss++;
        end
        fetch_req = 1'b1;
        fetch_pc  = pc;
        @(negedge clock);
        fetch_req = 1'b0;
        if (expect_resp) begin
            check("ready low after accept", {31'b0, fetch_ready}, 32'h0);
            t = 1;
            while (!fetch_valid && t < 60) begin
                @(negedge clock);
                t++;
            end
            check($sformatf("latency pc=%h", pc), t, lat);
            check("miss_count", {16'b0, miss_count}, {16'b0, exp_miss});
        end
    endtask

    initial begin
        int t;
        repeat (3) @(negedge clock);
        check("rst fetch_ready", {31'b0, fetch_ready}, 32'h1);
        check("rst fetch_valid", {31'b0, fetch_valid}, 32'h0);
        check("rst fetch_instr", fetch_instr, 32'h0);
        check("rst mem_req_valid", {31'b0, mem_req_valid}, 32'h0);
        check("rst mem_req_addr", mem_req_addr, 32'h0);
        check("rst miss_count", {16'b0, miss_count}, 32'h0);
        reset = 1'b0;
        @(negedge clock);

        // Cold miss, hits on the same line, conflict eviction in set 0.
        fetch(32'h100, 1, 4, 1);
        fetch(32'h100, 0, 1, 1);
        fetch(32'h104, 0, 1, 1);
        fetch(32'h180, 1, 4, 1);
        fetch(32'h100, 1, 4, 1);
        check("miss_count after eviction", {16'b0, miss_count}, 32'h3);

        // Request held off for 5 cycles with a stray response during REQ.
        stall = 5;
        stray = 1'b1;
        fetch(32'h2C0, 1, 9, 1);
        stall = 0;
        stray = 1'b0;
        fetch(32'h2C4, 0, 1, 1);

        // Invalidate coinciding with the fill.
        inval_on_resp = 1'b1;
        fetch(32'h3C8, 1, 4, 1);
        inval_on_resp = 1'b0;
        @(negedge clock);
        check("ready low while inval pending", {31'b0, fetch_ready}, 32'h0);
        @(negedge clock);
        check("ready back after inval", {31'b0, fetch_ready}, 32'h1);
        fetch(32'h3C8, 1, 4, 1);
        fetch(32'h2C0, 1, 4, 1);

        // Reset while waiting for the refill, then a late response.
        drop_resp = 1'b1;
        fetch(32'h100, 1, 0, 0);
        t = 0;
        while (!parked && t < 30) begin
            @(negedge clock);
            t++;
        end
        check("reached WAIT", {31'b0, parked}, 32'h1);
        reset = 1'b1;
        @(negedge clock);
        reset        = 1'b0;
        release_resp = 1'b1;
        exp_miss     = '0;
        repeat (4) @(negedge clock);
        check("miss_count after reset", {16'b0, miss_count}, 32'h0);
        check("mem_req_valid after reset", {31'b0, mem_req_valid}, 32'h0);
        check("fetch_instr after reset", fetch_instr, 32'h0);
        release_resp = 1'b0;
        drop_resp    = 1'b0;
        fetch(32'h100, 1, 4, 1);

        // Saturation: preset the counter near the top, then miss repeatedly.
        force dut.miss_count = 16'hFFFD;
        @(negedge clock);
        release dut.miss_count;
        exp_miss = 16'hFFFD;
        for (int k = 0; k < 4; k++) begin
            fetch((k % 2 == 0) ? 32'h1000 : 32'h1800, 1, 4, 1);
        end
        check("miss_count saturated", {16'b0, miss_count}, 32'hFFFF);

        repeat (5) @(negedge clock);
        check("pending fetch responses", exp_q.size(), 32'h0);
        check("pending mem requests", addr_q.size(), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/icache_refill_ctrl.md
# icache_refill_ctrl

Refill controller and tag store for the 16-set, direct-mapped instruction cache. It sits between the fetch stage and a single-level backing memory. It accepts one fetch at a time, returns hits one cycle after acceptance, and sequences a miss through a valid/ready request and a response-valid return, installing the line before replying. It replaces preloaded or poisoned fills with real refills and keeps a saturating miss counter for bring-up.

## Interface
- SETS, 16, number of sets; power of two; one 32-bit word per line
- ADDR_W, 32, fetch address width
- clock  in  1  main clock; all state updates on posedge
- reset  in  1  synchronous, active-high
- fetch_req  in  1  fetch request; accepted when fetch_ready is high
- fetch_pc  in  ADDR_W  fetch address; sampled on acceptance
- fetch_ready  out  1  high only in IDLE with no pending invalidate
- fetch_valid  out  1  one-cycle pulse; fetch_instr is valid this cycle
- fetch_instr  out  32  returned instruction
- mem_req_valid  out  1  refill request to backing memory
- mem_req_ready  in  1  memory accepts the request
- mem_req_addr  out  ADDR_W  line address {block, 3'b000}
- mem_resp_valid  in  1  refill data valid; one beat
- mem_resp_data  in  32  refill word
- inval  in  1  one-cycle pulse; invalidate all lines
- miss_count  out  16  saturating count of misses since reset

## Operation
- Address split: block = pc[31:3]; set = block[3:0] (log2 SETS bits); tag = block[28:4]. pc[2:0] is ignored.
- Storage per set: valid bit, 25-bit tag, 32-bit data. Reset clears valid bits only. Tag and data contents are don't-care after reset.
- Hit means valid[set] is set and tag[set] equals the request tag.
- States: IDLE, LOOKUP, REQ, WAIT, RESP.
- IDLE: if fetch_req && fetch_ready, register pc and go to LOOKUP.
- LOOKUP on hit: fetch_valid=1 and fetch_instr=data[set], then go to IDLE.
- LOOKUP on miss: increment miss_count (saturate at 16'hFFFF) and go to REQ.
- REQ: mem_req_valid=1 and mem_req_addr={block,3'b000}, both held stable until mem_req_ready. On handshake go to WAIT.
- WAIT: on mem_resp_valid, write valid=1, tag and data into the set (evicting any prior line), capture the data, and go to RESP.
- RESP: fetch_valid=1 and fetch_instr=captured data, then go to IDLE.
- mem_resp_valid outside WAIT is ignored.
- inval sets a pending flag in any state. The flag is applied in IDLE: all valid bits are cleared and the flag is cleared in that cycle. fetch_ready is low while the flag is pending.
- inval in the same cycle as a WAIT fill: the fill is written, then cleared on the next IDLE. The in-flight fetch still returns the fetched data.
- Outputs in states other than those listed: fetch_valid=0, mem_req_valid=0. fetch_instr holds its last value.

## Timing
- Reset values: state=IDLE, fetch_ready=1, fetch_valid=0, fetch_instr=0, mem_req_valid=0, mem_req_addr=0, miss_count=0, all valid=0, pending inval=0.
- Reset mid-miss: back to IDLE on the next edge. The request is dropped and any later response is ignored.
- Hit latency: request accepted at edge N, fetch_valid high in cycle N+1, fetch_ready high again in cycle N+2.
- Miss latency: mem_req_valid rises in cycle N+2. Request handshake at cycle R, response at cycle S > R, fetch_valid in cycle S+1.
- Minimum miss latency: mem_req_ready=1 immediately and response one cycle later gives fetch_valid at N+4.
- Back-to-back hits: at most one accepted fetch every 2 cycles.
- A refill is visible to lookups starting the cycle after the WAIT write.

## Test plan
- Cold miss: after reset, fetch pc=0x100. Expect mem_req_addr=0x100 and miss_count=1. Respond 0x91000AD6 → fetch_valid with fetch_instr=0x91000AD6.
- Hit: fetch 0x100 again (also 0x104, same line) → fetch_valid one cycle after acceptance with 0x91000AD6. No mem_req_valid; miss_count stays 1.
- Request stall: hold mem_req_ready=0 for 5 cycles → mem_req_valid and mem_req_addr stable for all 5 cycles. A stray mem_resp_valid during REQ is ignored.
- Conflict eviction: fill 0x100 (set 0), then fetch 0x180 (same set, different tag) → miss and refill. A following fetch of 0x100 misses again; miss_count=3.
- Invalidate: pulse inval while in WAIT → fetch_instr is still the fill data, fetch_ready stays low for one IDLE cycle, and a refetch of the same pc misses.
- Reset mid-miss: assert reset in WAIT, then drive mem_resp_valid afterward → no fetch_valid, miss_count=0, and the next fetch of the same pc misses.
- Saturation: force 65,540 misses → miss_count stays at 0xFFFF.
